uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver: 8N1 by default, LSB first, idle-high line.
- Generates its own bit timing from the system clock with the team's baud arithmetic. One bit period is FREQ/BAUD_RATE + 1 clocks, so the receiver matches the existing transmit-side timing.
- Detects the start bit, samples each bit at mid-period, checks the stop bit and presents a parallel byte with a one-cycle valid strobe.
- Sits between the external rx pin and the host-side logic.

Parameters:
- FREQ, 1000000, system clock frequency in Hz.
- BAUD_RATE, 2400, line rate in bit/s. Bit period P = FREQ/BAUD_RATE + 1 clocks (integer division), which gives 417 at the defaults.
- DATA_BITS, 8, data bits per frame (1..16).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous and active-high; the only clock is clk.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last good received word; held until the next good frame.
- rx_valid  output  1  one-cycle pulse; rx_data is updated in the same cycle.
- rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Constants: P = FREQ/BAUD_RATE + 1; H = P/2 (integer). The bit counter is 32 bits wide and the bit index is clog2(DATA_BITS+1) bits wide.
- Reset (async, any state): state=IDLE, counter=0, index=0, shift register=0, rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0. Both synchronizer flops reset to 1. Reset mid-frame abandons the frame with no strobe.
- Input: 2-flop synchronizer. rxs is the second flop. All decisions use rxs only, so pin-to-rxs latency is 2 cycles.
- IDLE: if rxs==0, go to START with counter=0.
- START:
  - counter increments each cycle.
  - At counter==H-1 (mid start bit): if rxs==0, go to DATA with counter=0 and index=0. If rxs==1, treat as a glitch and return to IDLE with no strobe.
- DATA:
  - counter increments each cycle.
  - At counter==P-1: shift rxs in LSB first (bit 0 is received first), counter=0, index+1.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: at counter==P-1, sample rxs.
  - rxs==1: rx_data <= shift register, rx_valid=1 for one cycle, go to IDLE.
  - rxs==0: rx_frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. A line held low (break) therefore yields exactly one rx_frame_err and no further frames.
- rx_valid and rx_frame_err are never high together. Each is registered and deasserts on the following cycle.
- Back-to-back frames: a new start bit detected in IDLE on the cycle right after the stop sample is accepted. There is no dead time beyond the IDLE cycle.
- Latency: rx_valid rises 2 + 1 + H + DATA_BITS·P + P cycles (±1) after the start-bit falling edge at the pin. The requirement is sampling within ±1 cycle of each mid-bit point.
- No flow control: a new valid overwrites rx_data. The consumer must capture it on rx_valid.

Test Plan:
All tests use FREQ=1000000, BAUD_RATE=100000, so P=11 and H=5.
1. Reset check: assert rst mid-DATA, then release → all outputs 0, state IDLE. A frame sent next is received correctly.
2. Good frame: send 0xA5 with a P-cycle bit period → exactly one rx_valid with rx_data=0xA5, rx_frame_err=0, rx_busy low afterwards.
3. Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap → three rx_valid pulses in that order, spaced 10·P cycles (±1) apart.
4. Glitch: rx low for 3 cycles, then high → no rx_valid, no rx_frame_err, back in IDLE after H+2 cycles.
5. Framing error: send 0x55 with stop bit 0, then hold rx low for 50 cycles, then idle, then send 0x12 →
   - exactly one rx_frame_err and rx_data still the previous value;
   - no strobe while low;
   - 0x12 then received with rx_valid.
6. Baud tolerance: send 0x96 with the bit period stretched to 12 cycles, then squeezed to 10 cycles → rx_data=0x96 both times.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// parallel word output with one-cycle valid / framing-error strobes.
`timescale 1ns/1ps
module uart_rx #(
    parameter int FREQ      = 1000000,
    parameter int BAUD_RATE = 2400,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned BIT_PERIOD = FREQ / BAUD_RATE + 1;
    localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [31:0]   PERIOD_LAST = 32'(BIT_PERIOD - 1);
    localparam logic [31:0]   HALF_LAST   = 32'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 sync1_q;
    logic                 rxs_q;
    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // A start bit that is high again at its midpoint is a glitch.
            S_START: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == PERIOD_LAST) begin
                    shift_d = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rxs_q;
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == PERIOD_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end

            // Line held low after a bad stop bit: wait for idle before rearming.
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at P=11, H=5: table-driven frames, hand-written
// corner sequences and random frames checked against a queue of transmitted bytes.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int P = 11;
    localparam int H = 5;

    typedef struct {
        logic [7:0] data;
        int         skewLen;
        int         gap;
        logic [7:0] expData;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int         assertCount = 0;
    int         failCount = 0;
    int         cycleCount = 0;
    int         errCount = 0;
    int         overlapCount = 0;
    logic [7:0] gotQ[$];
    int         validCycleQ[$];
    logic [7:0] expQ[$];
    logic [7:0] errData = 8'h00;
    logic [7:0] lastGood;
    vec_t       vecs[6];

    always #5 clk = ~clk;

    uart_rx #(
        .FREQ(1000000),
        .BAUD_RATE(100000),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy(rx_busy)
    );

    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_valid) begin
                gotQ.push_back(rx_data);
                validCycleQ.push_back(cycleCount);
            end
            if (rx_frame_err) begin
                errCount++;
                errData = rx_data;
            end
            if (rx_valid && rx_frame_err) overlapCount++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame bits 1..3 (data bits 0..2) use skewLen cycles; all others use P.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int skewLen);
        logic [9:0] frame;
        int len;
        frame = {stopBit, b, 1'b0};
        for (int m = 0; m < 10; m++) begin
            rx = frame[m];
            len = (m >= 1 && m <= 3) ? skewLen : P;
            repeat (len) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int eCnt;
        int diff;
        logic [7:0] b;

        // Three skewed bits keep cumulative drift within the half-bit margin.
        vecs[0] = '{8'hA5, P, 6, 8'hA5};
        vecs[1] = '{8'h00, P, 0, 8'h00};
        vecs[2] = '{8'hFF, P, 0, 8'hFF};
        vecs[3] = '{8'h3C, P, 6, 8'h3C};
        vecs[4] = '{8'h96, 12, 6, 8'h96};
        vecs[5] = '{8'h96, 10, 6, 8'h96};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetData", 32'(rx_data), 32'h00);
        checkOutput("resetValid", 32'(rx_valid), 32'h0);
        checkOutput("resetFrameErr", 32'(rx_frame_err), 32'h0);
        checkOutput("resetBusy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        idle(5);

        applyStimulus(8'h5A, 1'b1, P);
        idle(5);
        checkOutput("preResetData", 32'(rx_data), 32'h5A);
        gotQ.delete();
        rx = 1'b0;
        repeat (4 * P + 2) @(posedge clk);
        #1;
        checkOutput("busyMidData", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        #2;
        checkOutput("midResetData", 32'(rx_data), 32'h00);
        checkOutput("midResetBusy", 32'(rx_busy), 32'h0);
        checkOutput("midResetValid", 32'(rx_valid), 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10 * P);
        checkOutput("afterResetBusy", 32'(rx_busy), 32'h0);
        checkOutput("afterResetNoStrobe", 32'(gotQ.size()), 32'd0);
        applyStimulus(8'hE7, 1'b1, P);
        idle(5);
        checkOutput("afterResetCount", 32'(gotQ.size()), 32'd1);
        if (gotQ.size() > 0) checkOutput("afterResetFrame", 32'(gotQ[0]), 32'hE7);

        gotQ.delete();
        validCycleQ.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, 1'b1, vecs[i].skewLen);
            idle(vecs[i].gap);
            if (vecs[i].gap >= 5) checkOutput($sformatf("busyIdle[%0d]", i), 32'(rx_busy), 32'h0);
        end
        idle(20);
        checkOutput("tableCount", 32'(gotQ.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < gotQ.size()) checkOutput($sformatf("tableData[%0d]", i), 32'(gotQ[i]), 32'(vecs[i].expData));
        end
        if (validCycleQ.size() >= 4) begin
            for (int i = 1; i < 3; i++) begin
                diff = validCycleQ[i+1] - validCycleQ[i];
                checkOutput($sformatf("b2bSpacing[%0d]", i), 32'(diff >= 10 * P - 1 && diff <= 10 * P + 1), 32'h1);
            end
        end
        lastGood = vecs[5].expData;

        gotQ.delete();
        eCnt = errCount;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        checkOutput("glitchBusy", 32'(rx_busy), 32'h1);
        repeat (H + 4) @(posedge clk);
        #1;
        checkOutput("glitchIdle", 32'(rx_busy), 32'h0);
        idle(20);
        checkOutput("glitchNoValid", 32'(gotQ.size()), 32'd0);
        checkOutput("glitchNoErr", 32'(errCount - eCnt), 32'd0);

        gotQ.delete();
        eCnt = errCount;
        applyStimulus(8'h55, 1'b0, P);
        rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checkOutput("breakBusy", 32'(rx_busy), 32'h1);
        checkOutput("frameErrCount", 32'(errCount - eCnt), 32'd1);
        checkOutput("breakNoValid", 32'(gotQ.size()), 32'd0);
        checkOutput("frameErrDataHeld", 32'(errData), 32'(lastGood));
        checkOutput("breakDataHeld", 32'(rx_data), 32'(lastGood));
        idle(10);
        checkOutput("breakReleaseIdle", 32'(rx_busy), 32'h0);
        applyStimulus(8'h12, 1'b1, P);
        idle(5);
        checkOutput("postBreakErrCount", 32'(errCount - eCnt), 32'd1);
        checkOutput("postBreakCount", 32'(gotQ.size()), 32'd1);
        if (gotQ.size() > 0) checkOutput("postBreakFrame", 32'(gotQ[0]), 32'h12);

        gotQ.delete();
        expQ.delete();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            applyStimulus(b, 1'b1, P);
            expQ.push_back(b);
            idle(int'($urandom_range(0, 6)));
        end
        idle(20);
        checkOutput("randCount", 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < gotQ.size()) checkOutput($sformatf("randData[%0d]", i), 32'(gotQ[i]), 32'(expQ[i]));
        end
        checkOutput("randLastData", 32'(rx_data), 32'(expQ[expQ.size()-1]));
        checkOutput("validErrOverlap", 32'(overlapCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
